// File: rtl/mux_arbiter.sv
// mux_arbiter: two-requester round-robin arbiter that owns the select line of a
// shared 2:1 data mux. Grants, sel and the tie-break history are registered.
// y is a purely combinational function of sel, a and b.
module mux_arbiter #(
    parameter int WIDTH    = 1,
    parameter int MAX_HOLD = 8  // legal values >= 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req0,
    input  logic             req1,
    input  logic             done0,
    input  logic             done1,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             gnt0,
    output logic             gnt1,
    output logic             sel,
    output logic [WIDTH-1:0] y,
    output logic             valid
);

    localparam int CNT_W = (MAX_HOLD > 2) ? $clog2(MAX_HOLD) : 1;
    localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(MAX_HOLD - 1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        GRANT0 = 2'd1,
        GRANT1 = 2'd2
    } state_t;

    state_t           state;
    logic [CNT_W-1:0] hold_cnt;
    logic             last;   // requester that most recently released

    // The owner gives up the grant when it is done, stops asking, or has used
    // its full hold window while the other side is waiting.
    logic hold_expired;
    logic release0;
    logic release1;

    assign hold_expired = (hold_cnt == HOLD_LAST);
    assign release0     = done0 | ~req0 | (req1 & hold_expired);
    assign release1     = done1 | ~req1 | (req0 & hold_expired);

    // Arbitration state machine with registered grant and select outputs
    // NOTE: every register here uses <= so all of them update from the same
    // pre-edge values; a blocking = would let later lines see half-updated state.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            gnt0     <= 1'b0;
            gnt1     <= 1'b0;
            sel      <= 1'b0;
            hold_cnt <= '0;
            last     <= 1'b1;   // requester 0 wins the first tie
        end else begin
            case (state)
                IDLE: begin
                    hold_cnt <= '0;
                    if (req0 && (!req1 || last)) begin
                        state <= GRANT0;
                        gnt0  <= 1'b1;
                        sel   <= 1'b0;
                    end else if (req1) begin
                        state <= GRANT1;
                        gnt1  <= 1'b1;
                        sel   <= 1'b1;
                    end
                end

                GRANT0: begin
                    if (release0) begin
                        last     <= 1'b0;
                        hold_cnt <= '0;
                        gnt0     <= 1'b0;
                        if (req1) begin
                            // Direct hand-off: no idle cycle between owners
                            state <= GRANT1;
                            gnt1  <= 1'b1;
                            sel   <= 1'b1;
                        end else begin
                            state <= IDLE;
                        end
                    end else if (!hold_expired) begin
                        // Saturates at the limit so an uncontested owner keeps the bus
                        hold_cnt <= hold_cnt + CNT_W'(1);
                    end
                end

                GRANT1: begin
                    if (release1) begin
                        last     <= 1'b1;
                        hold_cnt <= '0;
                        gnt1     <= 1'b0;
                        if (req0) begin
                            state <= GRANT0;
                            gnt0  <= 1'b1;
                            sel   <= 1'b0;
                        end else begin
                            state <= IDLE;
                        end
                    end else if (!hold_expired) begin
                        hold_cnt <= hold_cnt + CNT_W'(1);
                    end
                end

                default: begin
                    state    <= IDLE;
                    gnt0     <= 1'b0;
                    gnt1     <= 1'b0;
                    hold_cnt <= '0;
                end
            endcase
        end
    end

    // Shared bus: always exactly one of the two sources, never a blend
    assign y     = sel ? b : a;
    assign valid = gnt0 | gnt1;

endmodule

// File: tb/tb_mux_arbiter.sv
// tb_mux_arbiter: directed scenarios followed by randomized traffic, checked
// against a tenure-counting reference model of the arbitration rules.
module tb_mux_arbiter;

    localparam int WIDTH    = 4;
    localparam int MAX_HOLD = 8;

    logic             clk;
    logic             rst;
    logic             req0, req1, done0, done1;
    logic [WIDTH-1:0] a, b;
    logic             gnt0, gnt1, sel, valid;
    logic [WIDTH-1:0] y;

    int checks = 0;
    int errors = 0;

    // Reference model: who owns the bus, how many cycles it has owned it,
    // who released last, and where the select line points.
    int   m_owner;   // -1 = nobody, 0 or 1 = requester index
    int   m_tenure;  // cycles the current grant has been visible
    int   m_last;
    logic m_sel;

    mux_arbiter #(.WIDTH(WIDTH), .MAX_HOLD(MAX_HOLD)) dut (
        .clk   (clk),
        .rst   (rst),
        .req0  (req0),
        .req1  (req1),
        .done0 (done0),
        .done1 (done1),
        .a     (a),
        .b     (b),
        .gnt0  (gnt0),
        .gnt1  (gnt1),
        .sel   (sel),
        .y     (y),
        .valid (valid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_owner  = -1;
        m_tenure = 0;
        m_last   = 1;
        m_sel    = 1'b0;
    endtask

    task automatic model_grant(input int n);
        m_owner  = n;
        m_tenure = 0;
        m_sel    = (n == 1);
    endtask

    // One rising edge of the arbitration rules, using the inputs present at the edge
    task automatic model_edge();
        logic want[2];
        logic fin[2];
        int   other;
        want[0] = req0; want[1] = req1;
        fin[0]  = done0; fin[1] = done1;
        if (m_owner < 0) begin
            if (want[0] && want[1])
                model_grant(m_last == 0 ? 1 : 0);
            else if (want[0])
                model_grant(0);
            else if (want[1])
                model_grant(1);
        end else begin
            other    = 1 - m_owner;
            m_tenure = m_tenure + 1;
            if (fin[m_owner] || !want[m_owner] || (want[other] && m_tenure >= MAX_HOLD)) begin
                m_last = m_owner;
                if (want[other])
                    model_grant(other);
                else
                    m_owner = -1;
            end
        end
    endtask

    task automatic compare_all(input string tag);
        check({tag, ".gnt0"},  32'(gnt0),  32'(m_owner == 0));
        check({tag, ".gnt1"},  32'(gnt1),  32'(m_owner == 1));
        check({tag, ".sel"},   32'(sel),   32'(m_sel));
        check({tag, ".valid"}, 32'(valid), 32'(m_owner >= 0));
        check({tag, ".y"},     32'(y),     32'(m_sel ? b : a));
    endtask

    // Advance one clock, update the model, then sample just after the edge
    task automatic step(input string tag);
        @(posedge clk);
        if (rst) model_reset();
        else     model_edge();
        #1;
        compare_all(tag);
    endtask

    task automatic drive(input logic r0, input logic r1, input logic d0, input logic d1);
        req0  = r0;
        req1  = r1;
        done0 = d0;
        done1 = d1;
    endtask

    // Step a and b through all four all-zero/all-one combinations within one cycle
    task automatic mux_sweep(input string tag);
        for (int i = 0; i < 4; i++) begin
            a = (i % 2 == 1) ? '1 : '0;
            b = (i / 2 == 1) ? '1 : '0;
            #1;
            check($sformatf("%s.combo%0d", tag, i), 32'(y), 32'(m_sel ? b : a));
        end
    endtask

    initial begin
        int cnt;

        // ---- Reset with both requesters asking ----
        rst = 1'b1;
        drive(1'b1, 1'b1, 1'b0, 1'b0);
        a = 4'h3;
        b = 4'hc;
        model_reset();
        #3;
        compare_all("rst_async");
        step("rst_held");
        check("rst_held.gnt0_low", 32'(gnt0), 32'd0);

        // ---- Release reset: requester 0 wins the first tie ----
        @(negedge clk);
        rst = 1'b0;
        step("rst_release");
        check("rst_release.gnt0", 32'(gnt0), 32'd1);
        check("rst_release.y_is_a", 32'(y), 32'(a));

        // ---- Single requester 1 ----
        drive(1'b0, 1'b0, 1'b0, 1'b0);
        step("to_idle");
        a = 4'h0;
        b = 4'h1;
        drive(1'b0, 1'b1, 1'b0, 1'b0);
        step("single1_grant");
        check("single1.y", 32'(y), 32'h1);
        drive(1'b0, 1'b1, 1'b0, 1'b1);
        step("single1_done");
        check("single1_done.sel_held", 32'(sel), 32'd1);
        check("single1_done.valid", 32'(valid), 32'd0);
        drive(1'b0, 1'b0, 1'b0, 1'b0);
        step("single1_idle");

        // ---- Round-robin tie with requester 0 as last releaser ----
        drive(1'b1, 1'b0, 1'b0, 1'b0);
        step("rr_setup_g0");
        drive(1'b0, 1'b0, 1'b0, 1'b0);
        step("rr_setup_idle");
        drive(1'b1, 1'b1, 1'b0, 1'b0);
        step("rr_tie");
        check("rr_tie.gnt1_first", 32'(gnt1), 32'd1);
        drive(1'b1, 1'b1, 1'b0, 1'b1);
        step("rr_handoff");
        check("rr_handoff.gnt0_no_bubble", 32'(gnt0), 32'd1);
        check("rr_handoff.sel", 32'(sel), 32'd0);

        // ---- Hold limit: requester 1 arrives one cycle after the grant ----
        drive(1'b0, 1'b0, 1'b0, 1'b0);
        step("hold_idle");
        drive(1'b1, 1'b0, 1'b0, 1'b0);
        step("hold_grant");
        cnt = gnt0 ? 1 : 0;
        drive(1'b1, 1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 40; i++) begin
            step("hold_run");
            if (!gnt0) break;
            cnt++;
        end
        check("hold.gnt0_cycles", 32'(cnt), 32'(MAX_HOLD));
        check("hold.gnt1_after", 32'(gnt1), 32'd1);

        // ---- Uncontested owner keeps the grant well past the limit ----
        drive(1'b1, 1'b0, 1'b0, 1'b0);
        step("persist_handoff");
        for (int i = 0; i < 25; i++) step("persist_run");
        check("persist.gnt0", 32'(gnt0), 32'd1);
        drive(1'b1, 1'b1, 1'b0, 1'b0);
        step("persist_preempt");
        check("persist_preempt.gnt1", 32'(gnt1), 32'd1);

        // ---- Asynchronous reset mid-grant ----
        drive(1'b0, 1'b1, 1'b0, 1'b0);
        step("arst_hold");
        #2;
        rst = 1'b1;
        #1;
        model_reset();
        check("arst.gnt1", 32'(gnt1), 32'd0);
        check("arst.valid", 32'(valid), 32'd0);
        check("arst.sel", 32'(sel), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        step("arst_regrant");
        check("arst_regrant.gnt1", 32'(gnt1), 32'd1);

        // ---- Mux sweep with sel = 1, then sel = 0 ----
        mux_sweep("sweep_sel1");
        drive(1'b0, 1'b0, 1'b0, 1'b0);
        step("sweep_idle");
        drive(1'b1, 1'b0, 1'b0, 1'b0);
        step("sweep_g0");
        mux_sweep("sweep_sel0");

        // ---- Randomized traffic, including the odd asynchronous reset ----
        for (int i = 0; i < 3000; i++) begin
            drive($urandom_range(0, 99) < 70, $urandom_range(0, 99) < 70,
                  $urandom_range(0, 99) < 10, $urandom_range(0, 99) < 10);
            a = WIDTH'($urandom);
            b = WIDTH'($urandom);
            if ($urandom_range(0, 199) == 0) begin
                #2;
                rst = 1'b1;
                #1;
                model_reset();
                compare_all("rand_arst");
                @(negedge clk);
                rst = 1'b0;
            end
            step("rand");
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/mux_arbiter.md
Name: mux_arbiter

Overview:
- Two-requester round-robin arbiter that owns the select line of a shared 2:1 datapath mux and drives the muxed output onto a single shared bus.
- Grants are registered. A grant is held until the owner signals done, drops its request, or exceeds a hold limit while the other requester waits.
- Sits between two bus masters and the shared downstream resource. It replaces free-running sel control.

Parameters:
- WIDTH, 1, data width of the a/b/y mux path
- MAX_HOLD, 8, maximum consecutive cycles one requester may hold the grant while the other is requesting (legal values >= 2)

Ports:
- clk  input  1  system clock, rising edge
- rst  input  1  asynchronous, active-high reset
- req0  input  1  requester 0 (input a) wants the resource
- req1  input  1  requester 1 (input b) wants the resource
- done0  input  1  requester 0 finished; release the grant (sampled only while gnt0=1)
- done1  input  1  requester 1 finished; release the grant (sampled only while gnt1=1)
- a  input  WIDTH  data from requester 0
- b  input  WIDTH  data from requester 1
- gnt0  output  1  grant to requester 0 (registered)
- gnt1  output  1  grant to requester 1 (registered)
- sel  output  1  mux select: 0 = a, 1 = b (registered)
- y  output  WIDTH  muxed data: sel ? b : a (combinational)
- valid  output  1  y carries granted data; equals gnt0 | gnt1

Behaviour:
- Reset (async, rst=1): state=IDLE, gnt0=0, gnt1=0, sel=0, valid=0, hold_cnt=0, last=1 (so requester 0 wins the first tie). Reset asserted mid-grant drops the grant immediately, without waiting for a clock edge.
- States: IDLE, GRANT0, GRANT1. gnt0=1 only in GRANT0, gnt1=1 only in GRANT1. Never both.
- IDLE:
  - req0 only -> GRANT0
  - req1 only -> GRANT1
  - both -> grant the requester != last
  - none -> stay in IDLE
- Latency: a request seen at edge N gives a grant visible after edge N (one cycle). sel updates on the same edge as the grant.
- sel in IDLE holds its last value. valid=0 in IDLE.
- GRANTn, release condition, evaluated each edge: done_n=1, OR req_n=0, OR (other req=1 AND hold_cnt==MAX_HOLD-1).
- On release:
  - other req=1 -> go directly to GRANT(other), no IDLE bubble; sel flips on the same edge
  - else -> IDLE
  - last <= n
- No release: stay in GRANTn.
- hold_cnt: width clog2(MAX_HOLD).
  - Cleared on every grant entry and in IDLE.
  - Increments each cycle in GRANTn.
  - Saturates at MAX_HOLD-1 when no competing request is present, so the owner keeps the grant indefinitely.
- Preemption applies only when the other requester is asserting. A requester preempted while still asserting req competes again via round-robin after the other side releases.
- Simultaneous done_n and req_n drop: treated as a single release.
- done of the non-granted requester: ignored.
- y is purely combinational from sel, a and b. y is undefined-safe: it is always a or b, never X, when inputs are known.

Test Plan:
- Reset: rst=1 with req0=req1=1 -> gnt0=gnt1=0, sel=0, valid=0. Release rst -> next edge gnt0=1, sel=0, y=a.
- Single requester: req1=1 only, b=1, a=0 -> one cycle later gnt1=1, sel=1, y=1, valid=1. done1 pulse -> next edge IDLE, valid=0, sel stays 1.
- Round-robin tie: both req asserted from IDLE with last=0 -> gnt1 first. On done1 with req0 still high -> gnt0 on the very next edge (no bubble), sel 1->0.
- Hold limit: MAX_HOLD=8, req0 held high with no done, req1 raised on the cycle after gnt0 -> gnt0 for exactly 8 cycles, then gnt1. With req1 low, gnt0 persists for 20+ cycles.
- Async reset mid-grant: in GRANT1, assert rst between clock edges -> gnt1, valid and sel go to 0 immediately. After release with req1=1 -> gnt1 returns after one edge.
- Mux sweep: hold a grant and step a/b through all four combinations 00/10/01/11 for sel=0 and sel=1 -> y equals a when sel=0 and b when sel=1 in every case.
